// File: rtl/test4_sweep_pkg.sv
// Shared types and constants for the test4 sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test4_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } sweep_state_t;

  localparam int NUM_VEC = 8;

  // good = y ^ (a & b) over vectors {a,b,y} = 0..7
  localparam logic [NUM_VEC-1:0] TEST4_EXP_MASK = 8'h6A;

endpackage

// File: rtl/test4_sweep_if.sv
// Control/result bundle between a sweep requester and test4_sweep.
// Latency: n/a (wires only).
// Backpressure: none; start is a single-cycle request honoured only when idle.
//   master: drives start, observes busy/done/results
//   slave : the sequencer, consumes start, produces busy/done/results
interface test4_sweep_if;
  import test4_sweep_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] good_mask;
  logic [3:0]         pass_count;
  logic               match;

  modport master (
    output start,
    input  busy, done, good_mask, pass_count, match
  );

  modport slave (
    input  start,
    output busy, done, good_mask, pass_count, match
  );

endinterface

// File: rtl/test4.sv
// Structural checker under test: good = y ^ (a & b).
// Latency: combinational.
// Backpressure: none.
//   a, b, y : stimulus lines, good : checker verdict
module test4 (
  input  wire a,
  input  wire b,
  input  wire y,
  output wire good
);

  wire w_ab;

  assign w_ab = a & b;
  assign good = y ^ w_ab;

endmodule

// File: rtl/tristate.sv
// Single-bit tri-state output buffer.
// Latency: combinational.
// Backpressure: none; q floats whenever en is low.
//   en : drive enable, d : data, q : shared line
module tristate (
  input  wire en,
  input  wire d,
  output wire q
);

  assign q = en ? d : 1'bz;

endmodule

// File: rtl/test4_sweep.sv
// Sweeps all eight {a,b,y} vectors into test4, samples good after SETTLE idle cycles, scores results.
// Latency: 8 x (SETTLE + 2) busy cycles after an accepted start, then a one-cycle done pulse.
// Backpressure: start is ignored outside IDLE (no queueing); lines float in IDLE and DONE.
//   clk, reset (sync, active-high) ; good_i : test4 verdict (tri) ; a_o/b_o/y_o : stimulus (tri)
//   ctl : start request, busy/done status, good_mask / pass_count / match results
module test4_sweep
  import test4_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE   = 1,
  parameter logic [NUM_VEC-1:0] EXP_MASK = TEST4_EXP_MASK
) (
  input  logic  clk,
  input  logic  reset,
  input  wire   good_i,
  output wire   a_o,
  output wire   b_o,
  output wire   y_o,
  test4_sweep_if.slave ctl
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [2:0] LAST_IDX   = 3'(NUM_VEC - 1);

  sweep_state_t       r_state;
  sweep_state_t       w_state_nxt;
  logic [2:0]         r_idx;
  logic [3:0]         r_cnt;
  logic [NUM_VEC-1:0] r_mask;
  logic [3:0]         r_count;
  logic               r_match;

  logic               w_busy;
  logic               w_done;
  logic               w_pass;
  logic [NUM_VEC-1:0] w_mask_upd;

  // Z or X on the verdict line is scored as a fail and never leaks into state.
  assign w_pass = (good_i === 1'b1);

  always_comb begin
    w_mask_upd        = r_mask;
    w_mask_upd[r_idx] = w_pass;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctl.start) w_state_nxt = DRIVE;
      end
      DRIVE: begin
        w_busy      = 1'b1;
        w_state_nxt = (SETTLE_CNT != 4'd0) ? WAIT : SAMPLE;
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_cnt <= 4'd1) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        w_busy      = 1'b1;
        w_state_nxt = (r_idx == LAST_IDX) ? DONE : DRIVE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_mask  <= '0;
      r_count <= 4'd0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (ctl.start) begin
            r_idx   <= 3'd0;
            r_mask  <= '0;
            r_count <= 4'd0;
            r_match <= 1'b0;
          end
        end
        DRIVE: r_cnt <= SETTLE_CNT;
        WAIT:  r_cnt <= r_cnt - 4'd1;
        SAMPLE: begin
          r_mask <= w_mask_upd;
          if (w_pass) r_count <= r_count + 4'd1;
          // match is settled on the last sample so it is already valid while done is high
          if (r_idx == LAST_IDX) r_match <= (w_mask_upd == EXP_MASK);
          else                   r_idx   <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign ctl.busy       = w_busy;
  assign ctl.done       = w_done;
  assign ctl.good_mask  = r_mask;
  assign ctl.pass_count = r_count;
  assign ctl.match      = r_match;

  // {a,b,y} = idx, driven only while a vector is in flight
  tristate u_drv_a (.en(w_busy), .d(r_idx[2]), .q(a_o));
  tristate u_drv_b (.en(w_busy), .d(r_idx[1]), .q(b_o));
  tristate u_drv_y (.en(w_busy), .d(r_idx[0]), .q(y_o));

endmodule

// File: tb/tb_test4_sweep.sv
// Bench for test4_sweep wired to a real test4: unit 0 uses SETTLE=1, unit 1 uses SETTLE=0.
// Latency: n/a.
// Backpressure: n/a.
module tb_test4_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_d [2];
  logic       tb_en   [2];
  logic [2:0] tb_v    [2];
  logic [1:0] gmode   [2];  // 0: real test4 (with flips), 1: stuck at 1, 2: floating
  logic [7:0] flip    [2];

  wire        busy_o  [2];
  wire        done_o  [2];
  wire        match_o [2];
  wire [7:0]  mask_o  [2];
  wire [3:0]  cnt_o   [2];
  wire [2:0]  line_o  [2];

  for (genvar g = 0; g < 2; g++) begin : g_unit
    test4_sweep_if ifc ();
    wire a_w, b_w, y_w, good_w, good_t4, gval;

    assign ifc.start = start_d[g];

    test4_sweep #(.SETTLE(g == 0 ? 1 : 0)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .good_i (good_w),
      .a_o    (a_w),
      .b_o    (b_w),
      .y_o    (y_w),
      .ctl    (ifc)
    );

    test4 u_t4 (.a(a_w), .b(b_w), .y(y_w), .good(good_t4));

    // bench as a second bus source, legal only while the sweeper floats the lines
    assign a_w = tb_en[g] ? tb_v[g][2] : 1'bz;
    assign b_w = tb_en[g] ? tb_v[g][1] : 1'bz;
    assign y_w = tb_en[g] ? tb_v[g][0] : 1'bz;

    assign gval   = (gmode[g] == 2'd1) ? 1'b1 : (good_t4 ^ flip[g][{a_w, b_w, y_w}]);
    assign good_w = (gmode[g] != 2'd2) ? gval : 1'bz;

    assign busy_o[g]  = ifc.busy;
    assign done_o[g]  = ifc.done;
    assign match_o[g] = ifc.match;
    assign mask_o[g]  = ifc.good_mask;
    assign cnt_o[g]   = ifc.pass_count;
    assign line_o[g]  = {a_w, b_w, y_w};
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected verdict per vector straight from the checker's boolean rule.
  function automatic logic [7:0] model_mask(input logic [1:0] mode, input logic [7:0] fl);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        2'd1:    m[i] = 1'b1;
        2'd2:    m[i] = 1'b0;
        default: m[i] = (i[0] ^ (i[2] & i[1])) ^ fl[i];
      endcase
    end
    return m;
  endfunction

  task automatic sweep(input int u, input logic [1:0] mode, input logic [7:0] fl,
                       input int busy_start_n, input bit done_start, input int reset_n,
                       input bit chain, input bit pre);
    int         per   = (u == 0) ? 3 : 2;
    int         nbusy = 8 * per;
    logic [7:0] em    = model_mask(mode, fl);
    int         busy_bad = 0, busy_cnt = 0, vec_bad = 0, done_cnt = 0, done_n = 0;
    logic [7:0] mask_d  = 8'h00;
    logic [3:0] cnt_d   = 4'd0;
    logic       match_d = 1'b0;
    gmode[u] = mode;
    flip[u]  = fl;
    if (!pre) begin
      tb_v[u]  = 3'($urandom_range(0, 7));
      tb_en[u] = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("idle_share_a", 32'(line_o[u]), 32'(tb_v[u]));
      tb_v[u] = ~tb_v[u];
      @(posedge clk); @(negedge clk);
      chk("idle_share_b", 32'(line_o[u]), 32'(tb_v[u]));
      chk("idle_busy", 32'(busy_o[u]), 32'd0);
      tb_en[u]   = 1'b0;
      start_d[u] = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    start_d[u] = 1'b0;
    for (int n = 1; n <= nbusy + 2; n++) begin
      if (n > 1) begin @(posedge clk); @(negedge clk); end
      if (n == 1) chk("cleared_on_start", 32'({mask_o[u], cnt_o[u], match_o[u]}), 32'd0);
      start_d[u] = (n == busy_start_n) || (done_start && n == nbusy + 1);
      if (busy_o[u] !== (n <= nbusy)) busy_bad++;
      if (busy_o[u] === 1'b1) begin
        busy_cnt++;
        if (line_o[u] !== 3'((n - 1) / per)) vec_bad++;
      end
      if (done_o[u] === 1'b1) begin
        done_cnt++;
        done_n  = n;
        mask_d  = mask_o[u];
        cnt_d   = cnt_o[u];
        match_d = match_o[u];
      end
      if (n == reset_n) begin
        int dcnt = 0;
        chk("rst_vec_idx3", 32'(line_o[u]), 32'd3);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rst_clear", 32'({busy_o[u], done_o[u], mask_o[u], cnt_o[u], match_o[u]}), 32'd0);
        for (int k = 0; k < 30; k++) begin
          @(posedge clk); @(negedge clk);
          if (done_o[u] === 1'b1 || busy_o[u] === 1'b1) dcnt++;
        end
        chk("rst_no_done", 32'(dcnt), 32'd0);
        return;
      end
    end
    start_d[u] = 1'b0;
    chk("busy_shape", 32'(busy_bad), 32'd0);
    chk("busy_width", 32'(busy_cnt), 32'(nbusy));
    chk("vec_order", 32'(vec_bad), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_n), 32'(nbusy + 1));
    chk("mask", 32'(mask_d), 32'(em));
    chk("pass_count", 32'(cnt_d), 32'($countones(em)));
    chk("match", 32'(match_d), 32'(em == 8'h6A));
    chk("hold", 32'({mask_o[u], match_o[u]}), 32'({em, em == 8'h6A}));
    if (chain) start_d[u] = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_d[i] = 1'b0;
      tb_en[i]   = 1'b0;
      tb_v[i]    = 3'd0;
      gmode[i]   = 2'd0;
      flip[i]    = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", 32'({busy_o[i], done_o[i], mask_o[i], cnt_o[i], match_o[i]}), 32'd0);

    sweep(0, 2'd0, 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);   // golden, SETTLE=1
    sweep(0, 2'd1, 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);   // good stuck at 1
    sweep(0, 2'd2, 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);   // good floating
    sweep(1, 2'd0, 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);   // SETTLE=0
    sweep(0, 2'd0, 8'h00, 7, 1'b1, 0, 1'b1, 1'b0);   // stray starts, then back-to-back
    sweep(0, 2'd0, 8'h00, 0, 1'b0, 0, 1'b0, 1'b1);
    sweep(0, 2'd0, 8'h00, 0, 1'b0, 11, 1'b0, 1'b0);  // reset in WAIT of vector 3
    sweep(0, 2'd0, 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);
    sweep(0, 2'd0, 8'h40, 0, 1'b0, 0, 1'b0, 1'b0);   // vector 6 flipped

    for (int r = 0; r < 8; r++) begin
      int u = int'($urandom_range(0, 1));
      int nb = (u == 0) ? 24 : 16;
      sweep(u, 2'($urandom_range(0, 2)), 8'($urandom), int'($urandom_range(0, nb)),
            1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/test4_sweep.md
# test4_sweep

Self-checking stimulus sequencer and scoreboard for the `test4` structural checker. It drives all eight `{a, b, y}` input combinations onto shared tri-state lines and samples `good` after a programmable settle interval. It then reports a per-vector pass mask, a pass count, and a match flag against a golden mask. It sits directly upstream of `test4`, feeding its `a`/`b`/`y` inputs, and directly downstream of it, consuming `good`.

## Interface
- `SETTLE`, default 1: idle cycles between driving a vector and sampling `good`. Legal range 0–15.
- `EXP_MASK`, default 8'h6A: golden pass mask. Bit i is the expected `good` for vector i. The default encodes good = y ^ (a & b).
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. One clock, synchronous active-high reset (fixed).
- `start` input 1: single-cycle request to begin a sweep. Honoured only in IDLE.
- `good_i` input 1 (tri): `test4.good`.
- `a_o`, `b_o`, `y_o` output 1 (tri): stimulus lines. High-Z when not driving.
- `busy` output 1: high from the cycle after an accepted `start` through the last SAMPLE.
- `done` output 1: one-cycle pulse after the last vector is sampled.
- `good_mask` output 8: bit i = sampled `good` for vector i.
- `pass_count` output 4: number of ones in `good_mask`, 0–8.
- `match` output 1: `good_mask == EXP_MASK`. Valid from `done` until the next accepted `start`.

## Operation
- **Vector index.** `idx` is 3 bits. The driven vector is `{a_o, b_o, y_o} = idx`, sweeping 0 to 7 in order.
- **States.** IDLE, DRIVE, WAIT, SAMPLE, DONE.
- **IDLE.**
  - `a_o`/`b_o`/`y_o` are Z and `busy` = 0.
  - On `start`: clear `good_mask`, `pass_count`, `match` and `idx`, then go to DRIVE.
- **DRIVE.**
  - Drive `idx` and load the settle counter with `SETTLE`.
  - Go to WAIT if `SETTLE` > 0, else to SAMPLE.
- **WAIT.**
  - Keep driving and decrement the counter.
  - Go to SAMPLE when the counter reaches 1.
- **SAMPLE.**
  - Keep driving.
  - At the closing edge: `good_mask[idx]` <= (`good_i` === 1'b1), and `pass_count` increments on a pass.
  - If `idx` == 7, go to DONE; else increment `idx` and go to DRIVE.
- **DONE.**
  - Lines are Z, `done` = 1 and `match` is updated.
  - Next state is IDLE unconditionally.
- **Sampling `good_i`.** A Z or X value counts as fail (0) and never propagates X into the mask or count.
- **Result hold.** `good_mask`, `pass_count` and `match` hold until the next accepted `start` or `reset`.
- **Ignored `start`.** `start` outside IDLE, including the DONE cycle, is ignored. There is no queueing.
- **Reset.**
  - `reset` has priority over everything, including mid-sweep.
  - It forces state IDLE, lines Z, and `busy` = `done` = `match` = 0, `good_mask` = 0, `pass_count` = 0, `idx` = 0.

## Timing
- **Reset values.** All outputs 0, and the tri lines Z.
- **Per-vector cost.** Each vector takes `SETTLE` + 2 cycles: DRIVE, `SETTLE` × WAIT, SAMPLE.
- **Sweep cycle counts.**
  - `start` accepted at edge k puts DRIVE for vector 0 in cycle k+1.
  - With `SETTLE` = 1, `done` is high in cycle k+25 (24 drive cycles).
  - With `SETTLE` = 0, `done` is high in cycle k+17.
- **`busy` width.** High exactly 8 × (`SETTLE` + 2) cycles. It is low in the DONE cycle.
- **Back-to-back sweeps.** A `start` asserted in the cycle after `done` (state IDLE) is accepted.
- **Drive windows.** Lines are actively driven only in DRIVE, WAIT and SAMPLE, so another source can share the bus in IDLE and DONE.

## Structure
- **Package `test4_sweep_pkg`:**
  - state enum `sweep_state_t` (IDLE, DRIVE, WAIT, SAMPLE, DONE);
  - `NUM_VEC` = 8;
  - `TEST4_EXP_MASK` = 8'h6A.
- **Output drivers.** Instantiate the existing `tristate` cell three times, with enable = `busy`. No new sub-module.
- **Bench DUT.** The bench wires `test4_sweep` to a real `test4`.

## Test plan
- **Golden DUT.** Real `test4`, `SETTLE` = 1, `start` pulse → `done` at +25 cycles, `good_mask` = 8'h6A, `pass_count` = 4, `match` = 1; lines Z before and after the sweep.
- **Stuck-at-1.** `good_i` forced 1 → `good_mask` = 8'hFF, `pass_count` = 8, `match` = 0. Forced Z → mask 8'h00, count 0, no X on any output.
- **`SETTLE` = 0.** `busy` high for exactly 16 cycles, each vector driven 2 cycles, and `done` at +17 with mask 8'h6A.
- **`start` while busy.** `start` re-pulsed while `busy` and in the DONE cycle → ignored; a single `done`, unchanged results. A `start` the cycle after `done` begins a new sweep with the mask cleared.
- **Reset mid-sweep.** `reset` while `idx` = 3 in WAIT → next cycle IDLE, lines Z, `busy` 0, mask/count 0, and no `done` pulse. A following `start` completes normally with 8'h6A.
- **Injected fault.** Bench flips `good_i` on vector 6 only → `good_mask` = 8'h2A, `pass_count` = 3, `match` = 0.
